// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage: decodes the immediate of a raw instruction
// word and presents it through a 2-entry skid buffer with valid/ready on both sides.
module imm_ext_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_ext_stage: XLEN must be 32 or 64");
  end

  logic             sgn;
  logic [63:0]      ext64;
  logic [XLEN-1:0]  ext_c;
  logic             ill_c;
  logic             unused_bits;

  assign sgn = instr[31];

  // Built at 64 bits and truncated, so one decode serves both XLEN values.
  always_comb begin
    ext64 = '0;
    ill_c = 1'b0;
    case (imm_src)
      3'b000: ext64 = {{52{sgn}}, instr[31:20]};
      3'b001: ext64 = {{52{sgn}}, instr[31:25], instr[11:7]};
      3'b010: ext64 = {{51{sgn}}, sgn, instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: ext64 = {{43{sgn}}, sgn, instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b100: ext64 = {{32{sgn}}, instr[31:12], 12'b0};
      3'b101: ext64 = {59'b0, instr[19:15]};
      3'b110: ext64 = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      default: begin
        ext64 = '0;
        ill_c = 1'b1;
      end
    endcase
  end

  assign ext_c       = ext64[XLEN-1:0];
  assign unused_bits = ^{instr[6:0], ext64};

  logic             o_valid, s_valid, rdy_q;
  logic [XLEN-1:0]  o_imm, s_imm;
  logic [TAG_W-1:0] o_tag, s_tag;
  logic             o_ill, s_ill;

  logic accept, consume;
  logic load_o_from_s, load_o_in, load_s;
  logic o_valid_nxt, s_valid_nxt;

  always_comb begin
    accept        = in_valid & rdy_q;
    consume       = o_valid & out_ready;
    load_o_from_s = consume & s_valid;
    load_o_in     = accept & (~o_valid | consume);
    load_s        = accept & o_valid & ~consume;
    o_valid_nxt   = load_o_from_s | load_o_in | (o_valid & ~consume);
    s_valid_nxt   = load_s | (s_valid & ~consume);
  end

  // in_ready comes straight from rdy_q so it has no combinational input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      rdy_q   <= 1'b1;
      o_imm   <= '0;
      o_tag   <= '0;
      o_ill   <= 1'b0;
      s_imm   <= '0;
      s_tag   <= '0;
      s_ill   <= 1'b0;
    end else if (flush) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      o_valid <= o_valid_nxt;
      s_valid <= s_valid_nxt;
      rdy_q   <= ~s_valid_nxt;
      if (load_o_from_s) begin
        o_imm <= s_imm;
        o_tag <= s_tag;
        o_ill <= s_ill;
      end else if (load_o_in) begin
        o_imm <= ext_c;
        o_tag <= in_tag;
        o_ill <= ill_c;
      end
      if (load_s) begin
        s_imm <= ext_c;
        s_tag <= in_tag;
        s_ill <= ill_c;
      end
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = o_valid;
  assign imm_ext   = o_imm;
  assign out_tag   = o_tag;
  assign illegal   = o_ill;

endmodule
